// File: rtl/wdemux8_16_if.sv
// Write port and forwarded read port of the wdemux8_16 register file.
// The master drives the write request and read selects; the slave returns wr_ready and read data.
interface wdemux8_16_if;
    // Handshake: a write transfers on a rising clk edge where wr_valid && wr_ready.
    // wr_ready is !hold, and wr_valid carries no obligation to stay high while wr_ready is low.
    logic        wr_valid;
    logic        wr_ready;
    logic        hold;
    logic [2:0]  wr_sel;
    logic        wr_byte;
    logic [15:0] wr_data;
    logic [2:0]  rd_sel_a;
    logic [2:0]  rd_sel_b;
    logic [15:0] rd_a;
    logic [15:0] rd_b;

    modport master (
        output wr_valid, hold, wr_sel, wr_byte, wr_data, rd_sel_a, rd_sel_b,
        input  wr_ready, rd_a, rd_b
    );

    modport slave (
        input  wr_valid, hold, wr_sel, wr_byte, wr_data, rd_sel_a, rd_sel_b,
        output wr_ready, rd_a, rd_b
    );
endinterface

// File: rtl/wdemux8_16.sv
// Eight 16-bit registers with word/byte writes through a one-entry commit stage.
// Reads forward the staged write so that new data is visible one cycle after acceptance.
module wdemux8_16 (
    input  logic         clk,
    input  logic         rst,
    wdemux8_16_if.slave  bus,
    output logic [15:0]  r0,
    output logic [15:0]  r1,
    output logic [15:0]  r2,
    output logic [15:0]  r3,
    output logic [15:0]  r4,
    output logic [15:0]  r5,
    output logic [15:0]  r6,
    output logic [15:0]  r7,
    output logic         busy,
    output logic [7:0]   commit_cnt
);

    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic        stage_valid_q, stage_valid_d;
    logic [2:0]  stage_sel_q, stage_sel_d;
    logic        stage_byte_q, stage_byte_d;
    logic [7:0]  stage_hi_q, stage_hi_d;
    logic [7:0]  stage_lo_q, stage_lo_d;
    logic [7:0]  commit_cnt_q, commit_cnt_d;
    logic        accept;

    // Returns cur with the staged write applied if the stage targets register idx.
    // A byte stage uses sel[1:0] as the register and sel[2] as the byte lane.
    function automatic logic [15:0] overlay(input logic [15:0] cur, input logic [2:0] idx);
        logic [15:0] res;
        res = cur;
        if (stage_valid_q) begin
            if (!stage_byte_q) begin
                if (stage_sel_q == idx) res = {stage_hi_q, stage_lo_q};
            end else if ({1'b0, stage_sel_q[1:0]} == idx) begin
                if (stage_sel_q[2]) res[15:8] = stage_lo_q;
                else                res[7:0]  = stage_lo_q;
            end
        end
        return res;
    endfunction

    assign bus.wr_ready = !bus.hold;
    assign accept       = bus.wr_valid && !bus.hold;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = overlay(regs_q[i], 3'(i));
        end
        stage_valid_d = accept;
        stage_sel_d   = stage_sel_q;
        stage_byte_d  = stage_byte_q;
        stage_hi_d    = stage_hi_q;
        stage_lo_d    = stage_lo_q;
        if (accept) begin
            stage_sel_d  = bus.wr_sel;
            stage_byte_d = bus.wr_byte;
            // The upper data byte is meaningless for byte writes, so it is not kept.
            stage_hi_d   = bus.wr_byte ? 8'h00 : bus.wr_data[15:8];
            stage_lo_d   = bus.wr_data[7:0];
        end
        commit_cnt_d = commit_cnt_q + {7'd0, stage_valid_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 16'h0000;
            end
            stage_valid_q <= 1'b0;
            stage_sel_q   <= 3'd0;
            stage_byte_q  <= 1'b0;
            stage_hi_q    <= 8'h00;
            stage_lo_q    <= 8'h00;
            commit_cnt_q  <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
            stage_valid_q <= stage_valid_d;
            stage_sel_q   <= stage_sel_d;
            stage_byte_q  <= stage_byte_d;
            stage_hi_q    <= stage_hi_d;
            stage_lo_q    <= stage_lo_d;
            commit_cnt_q  <= commit_cnt_d;
        end
    end

    always_comb begin
        bus.rd_a = overlay(regs_q[bus.rd_sel_a], bus.rd_sel_a);
        bus.rd_b = overlay(regs_q[bus.rd_sel_b], bus.rd_sel_b);
    end

    assign r0         = regs_q[0];
    assign r1         = regs_q[1];
    assign r2         = regs_q[2];
    assign r3         = regs_q[3];
    assign r4         = regs_q[4];
    assign r5         = regs_q[5];
    assign r6         = regs_q[6];
    assign r7         = regs_q[7];
    assign busy       = stage_valid_q;
    assign commit_cnt = commit_cnt_q;

endmodule

// File: doc/wdemux8_16.md
WDEMUX8_16 -- requirements
Module: wdemux8_16

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: wr_valid  input  1  write request present.
REQ-004 SHALL have port: wr_ready  output  1  write port accepts this cycle.
REQ-005 SHALL have port: hold  input  1  stall request from pipeline control.
REQ-006 SHALL have port: wr_sel  input  3  destination select (register or byte register).
REQ-007 SHALL have port: wr_byte  input  1  1 = byte write, 0 = word write.
REQ-008 SHALL have port: wr_data  input  16  write data.
REQ-009 SHALL have port: rd_sel_a, rd_sel_b  input  3 each  word read selects.
REQ-010 SHALL have port: rd_a, rd_b  output  16 each  forwarded word read data.
REQ-011 SHALL have port: r0..r7  output  16 each  committed register contents, feeding downstream 8:1 read muxes.
REQ-012 SHALL have port: busy  output  1  staged write pending.
REQ-013 SHALL have port: commit_cnt  output  8  count of committed writes.

Function
REQ-014 SHALL compute wr_ready = !hold combinationally; a write is accepted on a rising edge where wr_valid && wr_ready.
REQ-015 SHALL capture an accepted write (sel, byte, data) into a one-entry stage register and set stage_valid.
REQ-016 SHALL commit a valid stage to the register array on the next rising edge unconditionally; hold SHALL NOT delay commit.
REQ-017 SHALL clear stage_valid after commit unless a new write is accepted on the same edge, in which case the stage reloads and stays valid.
REQ-018 SHALL drive busy = stage_valid.
REQ-019 SHALL, for a word write, load all 16 bits of register wr_sel.
REQ-020 SHALL, for a byte write, target register {0,wr_sel[1:0]}: low byte when wr_sel[2]=0, high byte when wr_sel[2]=1, with data from wr_data[7:0] and the other byte unchanged.
REQ-021 SHALL ignore wr_data[15:8] on byte writes.
REQ-022 SHALL update r0..r7 only on commit, so a write accepted at edge N is visible on rN outputs after edge N+1.
REQ-023 SHALL drive rd_a and rd_b combinationally as the committed register, overlaid with the staged write when stage_valid and the stage targets that register; byte stages overlay only their byte.
REQ-024 SHALL make forwarded data visible on rd_a/rd_b in the cycle after acceptance (latency 1).
REQ-025 SHALL give correct results for back-to-back writes to the same register, including a high-byte write followed by a low-byte write, with no lost bytes.
REQ-026 SHALL allow rd_sel_a == rd_sel_b; both outputs are then identical.
REQ-027 SHALL increment commit_cnt by 1 on each commit, wrapping 255 -> 0.
REQ-028 SHALL drop wr_valid silently while hold=1; no state changes.

Reset
REQ-029 SHALL, on rst assertion, immediately clear r0..r7 to 16'h0000, stage_valid to 0, commit_cnt to 0 and busy to 0.
REQ-030 SHALL discard a staged write in flight when rst asserts mid-operation; it never commits.
REQ-031 SHALL drive wr_ready = !hold during reset, but SHALL accept no writes while rst=1.

Verification
REQ-032 Word write wr_sel=3, data 16'hBEEF, accepted at edge N -> rd_a (sel 3) = 16'hBEEF after N; r3 = 16'hBEEF after N+1; commit_cnt = 1.
REQ-033 Byte writes on r2=16'h1234: sel=6 data 8'hAB, then sel=2 data 8'hCD on consecutive edges -> forwarded rd_b shows 16'hAB34, then 16'hABCD; final r2 = 16'hABCD.
REQ-034 hold=1 with wr_valid=1 and data 16'h5555 to sel=0 for 3 cycles -> wr_ready=0, r0 unchanged, commit_cnt unchanged, busy=0.
REQ-035 Accept write to r7, assert rst before the commit edge -> r7 = 16'h0000, busy=0, commit_cnt=0 after release.
REQ-036 256 consecutive accepted writes -> commit_cnt wraps 255 -> 0; busy stays 1 throughout and falls 1 cycle after the last accept.
REQ-037 Random word/byte writes with random read selects vs. a reference model -> rd_a, rd_b and r0..r7 match every cycle.
